// File: rtl/as_imem_arb.sv
// Single-port I-Mem controller: sequences JTAG loader traffic and core fetch, and holds the core in reset while loading.
// Optional macro AS_IMEM_ARB_DBG_EN enables loader access while the core runs, with fetch-starvation relief.
module as_imem_arb #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RST_HOLD   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              ld_mode_i,
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,
    output logic [DATA_W-1:0] ld_rdata_o,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              stall_o,
    output logic              core_rst_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    generate
        if (RST_HOLD < 1 || RST_HOLD > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_chk
            $error("as_imem_arb: RST_HOLD and STARVE_MAX must lie in 1..15");
        end
    endgenerate

    logic [1:0] state;
    logic [3:0] hold_cnt;
    logic       is_run;
    logic       is_load;
    logic       ld_force;
    logic       if_gnt;
    logic       ld_gnt;
    logic       rd_vld_p1;
    logic       rd_own_ld_p1;

    assign is_run  = (state == ST_RUN);
    assign is_load = (state == ST_LOAD);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= ST_IDLE;
            hold_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld_mode_i) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!ld_mode_i) begin
                        state    <= ST_RELEASE;
                        hold_cnt <= 4'(RST_HOLD - 1);
                    end
                end
                ST_RELEASE: begin
                    if (ld_mode_i) begin
                        state    <= ST_LOAD;
                        hold_cnt <= 4'd0;
                    end else if (hold_cnt == 4'd0) begin
                        state <= ST_RUN;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    if (ld_mode_i) state <= ST_LOAD;
                end
            endcase
        end
    end

    // Fetch loses the port the same cycle the loader takes ownership back.
    assign if_gnt = is_run & ~ld_mode_i & if_req_i & ~ld_force;

`ifdef AS_IMEM_ARB_DBG_EN
    logic [3:0] starve_cnt;

    assign ld_force = is_run & ~ld_mode_i & if_req_i & ld_req_i
                    & (starve_cnt == 4'(STARVE_MAX));
    assign ld_gnt   = ld_req_i & (is_load | (is_run & ~if_gnt));

    // Counts consecutive fetch wins over a waiting loader.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            starve_cnt <= 4'd0;
        end else if (!is_run || ld_mode_i || !ld_req_i || ld_gnt) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign ld_force = 1'b0;
    assign ld_gnt   = ld_req_i & is_load;
`endif

    assign if_gnt_o    = if_gnt;
    assign ld_gnt_o    = ld_gnt;
    assign stall_o     = if_req_i & ~if_gnt;
    assign core_rst_o  = ~is_run;

    assign mem_en_o    = if_gnt | ld_gnt;
    assign mem_we_o    = ld_gnt & ld_we_i;
    assign mem_addr_o  = ld_gnt ? ld_addr_i : (if_gnt ? if_addr_i : '0);
    assign mem_wdata_o = ld_gnt ? ld_wdata_i : '0;

    // Stage p0 -> p1: remember who owns the read issued this cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_vld_p1    <= 1'b0;
            rd_own_ld_p1 <= 1'b0;
        end else begin
            rd_vld_p1    <= mem_en_o & ~mem_we_o;
            rd_own_ld_p1 <= ld_gnt;
        end
    end

    assign ld_rvalid_o = rd_vld_p1 & rd_own_ld_p1;
    assign if_rvalid_o = rd_vld_p1 & ~rd_own_ld_p1;
    assign ld_rdata_o  = mem_rdata_i;
    assign if_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_as_imem_arb.sv
// Directed bench for as_imem_arb with a behavioural single-port I-Mem attached.
module tb_as_imem_arb;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ld_mode, ld_req, ld_we, if_req;
    logic [AW-1:0] ld_addr, if_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt, ld_rvalid, if_gnt, if_rvalid, stall, core_rst;
    logic [DW-1:0] ld_rdata, if_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    as_imem_arb #(.ADDR_W(AW), .DATA_W(DW), .RST_HOLD(2), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rstn_i(rstn), .ld_mode_i(ld_mode),
        .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
        .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .stall_o(stall), .core_rst_o(core_rst),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we_cnt;
        int bad_ld, bad_stall, bad_we;
        rstn = 1'b0; ld_mode = 1'b0; ld_req = 1'b0; ld_we = 1'b0; if_req = 1'b0;
        ld_addr = '0; if_addr = '0; ld_wdata = '0;
        #2;
        chk("rst core_rst", core_rst, 1);
        chk("rst if_gnt", if_gnt, 0);
        chk("rst ld_gnt", ld_gnt, 0);
        chk("rst mem_en", mem_en, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst rvalid", {ld_rvalid, if_rvalid}, 0);
        #20 rstn = 1'b1;
        tick;

        // IDLE: no grants even with requests pending
        ld_req = 1'b1; ld_we = 1'b1; if_req = 1'b1;
        #1;
        chk("idle ld_gnt", ld_gnt, 0);
        chk("idle if_gnt", if_gnt, 0);
        chk("idle core_rst", core_rst, 1);
        ld_req = 1'b0;
        ld_mode = 1'b1;
        tick;

        // LOAD: four writes of addi x0,x0,0
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ld_req = 1'b1; ld_we = 1'b1; ld_addr = AW'(i); ld_wdata = 32'h0000_0013;
            if_req = 1'b1; if_addr = AW'(i);
            #1;
            chk("load ld_gnt", ld_gnt, 1);
            chk("load mem_we", mem_we, 1);
            chk("load if_gnt", if_gnt, 0);
            chk("load mem_addr", mem_addr, i);
            if (mem_we) we_cnt++;
            tick;
        end
        chk("load we count", we_cnt, 4);
        ld_addr = 10'h3FF; ld_wdata = 32'hDEAD_BEEF;
        #1;
        chk("top addr", mem_addr, 10'h3FF);
        chk("top wdata", mem_wdata, 32'hDEAD_BEEF);
        tick;
        ld_we = 1'b0; ld_addr = 10'd2;
        #1;
        chk("rd2 ld_gnt", ld_gnt, 1);
        chk("rd2 mem_we", mem_we, 0);
        tick;
        ld_addr = 10'h3FF;
        #1;
        chk("rd2 ld_rvalid", ld_rvalid, 1);
        chk("rd2 ld_rdata", ld_rdata, 32'h0000_0013);
        chk("rd2 if_rvalid", if_rvalid, 0);
        chk("rdtop ld_gnt", ld_gnt, 1);
        tick;
        ld_req = 1'b0;
        #1;
        chk("rdtop ld_rvalid", ld_rvalid, 1);
        chk("rdtop ld_rdata", ld_rdata, 32'hDEAD_BEEF);
        tick;
        chk("rd single pulse", ld_rvalid, 0);

        // Release with RST_HOLD=2
        ld_mode = 1'b0; if_req = 1'b1; if_addr = 10'd3;
        #1;
        chk("rel last load if_gnt", if_gnt, 0);
        chk("rel last load stall", stall, 1);
        tick;
        chk("rel c0 core_rst", core_rst, 1);
        chk("rel c0 if_gnt", if_gnt, 0);
        tick;
        chk("rel c1 core_rst", core_rst, 1);
        chk("rel c1 if_gnt", if_gnt, 0);
        tick;
        chk("run core_rst", core_rst, 0);
        chk("run if_gnt", if_gnt, 1);
        chk("run stall", stall, 0);
        chk("run mem_addr", mem_addr, 3);
        tick;
        chk("run if_rvalid", if_rvalid, 1);
        chk("run if_rdata", if_rdata, 32'h0000_0013);

`ifdef AS_IMEM_ARB_DBG_EN
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd2;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("shr ld_gnt", ld_gnt, (i % 5) == 4);
            chk("shr if_gnt", if_gnt, (i % 5) != 4);
            chk("shr stall", stall, (i % 5) == 4);
            chk("shr ld_rvalid", ld_rvalid, (i % 5) == 0 && i > 0);
            tick;
        end
        ld_req = 1'b0;
        #1;
        chk("shr tail ld_rvalid", ld_rvalid, 1);
        tick;
`else
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd3; ld_wdata = '0;
        bad_ld = 0; bad_stall = 0; bad_we = 0;
        for (int i = 0; i < 100; i++) begin
            if_req = ((i % 3) != 2);
            #1;
            if (ld_gnt) bad_ld++;
            if (stall) bad_stall++;
            if (mem_we) bad_we++;
            tick;
        end
        chk("blk ld_gnt cycles", bad_ld, 0);
        chk("blk stall cycles", bad_stall, 0);
        chk("blk mem_we cycles", bad_we, 0);
        ld_req = 1'b0; if_req = 1'b1;
        tick;
        chk("blk fetch data", if_rdata, 32'h0000_0013);
`endif

        // Handover: loader reclaims the port right after a fetch grant
        if_req = 1'b1; if_addr = 10'd3;
        #1;
        chk("hnd if_gnt", if_gnt, 1);
        tick;
        ld_mode = 1'b1;
        #1;
        chk("hnd if_rvalid", if_rvalid, 1);
        chk("hnd if_rdata", if_rdata, 32'h0000_0013);
        chk("hnd if_gnt stop", if_gnt, 0);
        chk("hnd core_rst same", core_rst, 0);
        tick;
        chk("hnd core_rst next", core_rst, 1);
        chk("hnd if_gnt next", if_gnt, 0);
        chk("hnd if_rvalid next", if_rvalid, 0);

        // Back to RUN, then reset with a read in flight
        ld_mode = 1'b0;
        tick; tick; tick;
        chk("rerun core_rst", core_rst, 0);
        chk("rerun if_gnt", if_gnt, 1);
        tick;
        chk("rerun if_rvalid", if_rvalid, 1);
        rstn = 1'b0;
        #1;
        chk("arst if_rvalid", if_rvalid, 0);
        chk("arst if_gnt", if_gnt, 0);
        chk("arst core_rst", core_rst, 1);
        chk("arst mem_en", mem_en, 0);
        tick;
        chk("arst later if_rvalid", if_rvalid, 0);
        #2 rstn = 1'b1;
        tick;
        chk("post rst core_rst", core_rst, 1);
        chk("post rst if_gnt", if_gnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/as_imem_arb.md
# as_imem_arb

Instruction-memory port controller for the RV64I no-pipeline core. It sequences the single-port I-Mem between the JTAG loader (program download and debug readback) and core instruction fetch. It holds the core in reset while a program is loaded and arbitrates fetch against loader traffic once the core runs. It sits between the core fetch stage, the TAP-side loader and the I-Mem macro inside `as_top_mem`.

## Interface
- `ADDR_W`, 10: I-Mem word address width.
- `DATA_W`, 32: instruction word width.
- `RST_HOLD`, 2: cycles `core_rst_o` stays high after the load ends, range 1..15.
- `STARVE_MAX`, 4: consecutive conflicting fetch wins before the loader is forced a grant, range 1..15.

Ports:
- `clk_i` in 1: core clock; the single clock of the block.
- `rstn_i` in 1: asynchronous reset, active-low.
- `ld_mode_i` in 1: loader owns the memory; already synchronized to `clk_i`.
- `ld_req_i` in 1, `ld_we_i` in 1, `ld_addr_i` in ADDR_W, `ld_wdata_i` in DATA_W: loader request.
- `ld_gnt_o` out 1, `ld_rvalid_o` out 1, `ld_rdata_o` out DATA_W: loader grant and read return.
- `if_req_i` in 1, `if_addr_i` in ADDR_W: core fetch request.
- `if_gnt_o` out 1, `if_rvalid_o` out 1, `if_rdata_o` out DATA_W: fetch grant and read return.
- `stall_o` out 1: equals `if_req_i & ~if_gnt_o`.
- `core_rst_o` out 1: synchronous reset to the core, active-high.
- `mem_en_o` out 1, `mem_we_o` out 1, `mem_addr_o` out ADDR_W, `mem_wdata_o` out DATA_W: I-Mem port.
- `mem_rdata_i` in DATA_W: I-Mem read data, valid 1 cycle after `mem_en_o & ~mem_we_o`.

## Operation
- **IDLE:** entered on reset.
  - `core_rst_o`=1; no grants.
  - Goes to LOAD when `ld_mode_i`=1.
- **LOAD:**
  - Only the loader is served: `ld_gnt_o = ld_req_i`, `if_gnt_o`=0, `core_rst_o`=1.
  - Goes to RELEASE when `ld_mode_i`=0.
- **RELEASE:**
  - No grants; `core_rst_o`=1.
  - A hold counter loads `RST_HOLD-1` on entry and decrements each cycle. At 0 the block goes to RUN.
  - `ld_mode_i`=1 here returns to LOAD and the counter is discarded.
- **RUN:**
  - `core_rst_o`=0. Fetch has priority.
  - `ld_mode_i`=1 goes to LOAD. Fetch grants stop in that same cycle; `core_rst_o`=1 from the next cycle.
- **Memory mux:** the granted requester drives `mem_addr_o`, `mem_wdata_o` and `mem_we_o`.
  - `mem_en_o` = any grant.
  - `mem_we_o` is only ever 1 for the loader; fetch is read-only.
- **Read return:** a 1-bit owner register records who was granted a read.
  - Next cycle, `ld_rvalid_o` or `if_rvalid_o` pulses for exactly 1 cycle.
  - Both `ld_rdata_o` and `if_rdata_o` equal `mem_rdata_i` unregistered; consumers sample only on their rvalid.
  - A read in flight when the state changes is still returned to its owner.
- **Writes:** no rvalid is returned.
- **Starvation counter (4 bit):**
  - Increments in each RUN cycle where `if_req_i` and `ld_req_i` are both high and fetch wins.
  - When it equals `STARVE_MAX`, the next conflicting cycle grants the loader, and the counter clears.
  - Also clears when `ld_req_i`=0 or outside RUN.
- **Address width:** addresses are used as-is; no wrap logic, and the full ADDR_W range is legal.

## Timing
- Grants are combinational, in the same cycle as the request.
- Read latency is 1 cycle from grant to rvalid. Back-to-back reads are allowed, with one per cycle of throughput.
- Requesters hold `req`/`addr`/`data` stable until granted.
- Reset values: `core_rst_o`=1, all other outputs 0, state IDLE, counters 0, owner register cleared.
- Reset asserted mid-operation aborts immediately: a pending rvalid is dropped and no write completes after `rstn_i` falls.

## Configuration
- Macro: `AS_IMEM_ARB_DBG_EN`.
- **Defined:** loader access in RUN is enabled, including the starvation counter, so debug readback and patching work while the core executes.
- **Undefined:** in RUN, `ld_gnt_o`=0 always and `ld_req_i` is ignored. The starvation counter and its compare logic are not synthesized. LOAD behaviour is unchanged.

## Test plan
- **Reset:** pulse `rstn_i` low mid-RUN with `if_req_i`=1 → same cycle `if_gnt_o`=0 and `core_rst_o`=1; no rvalid follows.
- **Load:** set `ld_mode_i`=1; write 0x00000013 to addresses 0..3, then read address 2 → `mem_we_o` pulses 4 times with `ld_gnt_o` in the same cycle; `ld_rvalid_o`=1 one cycle after the read grant with `ld_rdata_o`=0x00000013; `if_gnt_o` stays 0 throughout.
- **Release:** drop `ld_mode_i` with `RST_HOLD`=2 → `core_rst_o` falls exactly 2 cycles after RELEASE entry, and the first `if_gnt_o` comes in that cycle.
- **Shared RUN access (`AS_IMEM_ARB_DBG_EN` defined):** hold `if_req_i` and `ld_req_i` high for 20 cycles → repeating pattern of 4 fetch grants then 1 loader grant; `stall_o`=1 on loader cycles.
- **Loader blocked in RUN (`AS_IMEM_ARB_DBG_EN` undefined):** hold `ld_req_i` high for 100 RUN cycles → `ld_gnt_o` stays 0; `stall_o` stays 0 while fetching.
- **Handover:** raise `ld_mode_i` in the cycle of a fetch read grant → `if_rvalid_o`=1 next cycle; no further `if_gnt_o`; `core_rst_o`=1 next cycle.
